elastic_alu_output_stage: RTL and testbench

Output half of an elastic (SELF-protocol) CGRA processing element: ALU, then a FIFO elastic buffer, then an eager fork to neighbour PEs. It takes one joined operand pair per token, computes under the current context's opcode, buffers the result and broadcasts it to the neighbour outputs enabled by the context's output mask. It reports per-stage context-switch pulses to the PE's config sequencer, which supplies `op`, `const_data` and `output_mask`.

---
 rtl/elastic_alu_output_stage_pkg.sv | 30 +++
 rtl/elastic_alu_output_stage_if.sv | 49 ++++
 rtl/elastic_alu_output_stage_fifo.sv | 68 ++++++
 rtl/elastic_alu_output_stage_fork.sv | 39 +++
 rtl/elastic_alu_output_stage.sv | 96 +++++++++
 tb/tb_elastic_alu_output_stage.sv | 273 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/elastic_alu_output_stage_pkg.sv
// Shared definitions for the elastic ALU output stage: default widths,
// opcode encodings and the elastic wire bundle used between PE stages.
package elastic_alu_output_stage_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 32'd32;
    localparam int DEFAULT_ADDRESS_WIDTH = 32'd32;

    // Opcodes are compared after zero-extension to 32 bits, so any opcode
    // width works and values outside this table fall through to NOP.
    localparam logic [31:0] OP_NOP   = 32'd0;
    localparam logic [31:0] OP_ADD   = 32'd1;
    localparam logic [31:0] OP_SUB   = 32'd2;
    localparam logic [31:0] OP_MUL   = 32'd3;
    localparam logic [31:0] OP_AND   = 32'd4;
    localparam logic [31:0] OP_OR    = 32'd5;
    localparam logic [31:0] OP_XOR   = 32'd6;
    localparam logic [31:0] OP_SHL   = 32'd7;
    localparam logic [31:0] OP_SHR   = 32'd8;
    localparam logic [31:0] OP_CONST = 32'd9;
    localparam logic [31:0] OP_LOAD  = 32'd10;
    localparam logic [31:0] OP_STORE = 32'd11;

    // One elastic link: data qualified by valid, stop flowing backwards.
    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] data;
        logic                          valid;
        logic                          stop;
    } elastic_wire_t;

endpackage

// File: rtl/elastic_alu_output_stage_if.sv
// Bundle of every handshake, context and memory signal of the output stage.
// master = the stage itself, slave = the surrounding PE / environment.
interface elastic_alu_output_stage_if
    import elastic_alu_output_stage_pkg::*;
#(
    parameter int DATA_WIDTH           = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH        = DEFAULT_ADDRESS_WIDTH,
    parameter int OPERATION_BIT_LENGTH = 32'd4,
    parameter int NUM_OUTPUTS          = 32'd4,
    parameter int BUFFER_DEPTH         = 32'd2
) ();
    localparam int COUNT_WIDTH = $clog2(BUFFER_DEPTH) + 32'd1;

    logic [DATA_WIDTH-1:0]                   in_data_1;
    logic [DATA_WIDTH-1:0]                   in_data_2;
    logic                                    in_valid;
    logic                                    in_stop;
    logic [OPERATION_BIT_LENGTH-1:0]         op;
    logic [DATA_WIDTH-1:0]                   const_data;
    logic [NUM_OUTPUTS-1:0]                  output_mask;
    logic                                    switch_context_alu;
    logic                                    switch_context_fork;
    logic [ADDRESS_WIDTH-1:0]                memory_read_address;
    logic [DATA_WIDTH-1:0]                   memory_read_data;
    logic                                    memory_write;
    logic [ADDRESS_WIDTH-1:0]                memory_write_address;
    logic [DATA_WIDTH-1:0]                   memory_write_data;
    logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0]  out_data;
    logic [NUM_OUTPUTS-1:0]                  out_valid;
    logic [NUM_OUTPUTS-1:0]                  out_stop;
    logic [COUNT_WIDTH-1:0]                  buffer_count;

    modport master (
        input  in_data_1, in_data_2, in_valid, op, const_data, output_mask,
               memory_read_data, out_stop,
        output in_stop, switch_context_alu, switch_context_fork,
               memory_read_address, memory_write, memory_write_address,
               memory_write_data, out_data, out_valid, buffer_count
    );

    modport slave (
        output in_data_1, in_data_2, in_valid, op, const_data, output_mask,
               memory_read_data, out_stop,
        input  in_stop, switch_context_alu, switch_context_fork,
               memory_read_address, memory_write, memory_write_address,
               memory_write_data, out_data, out_valid, buffer_count
    );

endinterface

// File: rtl/elastic_alu_output_stage_fifo.sv
// Elastic FIFO buffer with occupancy count. Push is ignored when full and
// pop is ignored when empty; a simultaneous push and pop keeps the count.
module elastic_alu_output_stage_fifo #(
    parameter int WIDTH       = 32'd32,
    parameter int DEPTH       = 32'd2,
    parameter int COUNT_WIDTH = $clog2(DEPTH) + 32'd1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   empty,
    output logic                   full,
    output logic [COUNT_WIDTH-1:0] count
);
    localparam int PTR_WIDTH = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
    localparam logic [PTR_WIDTH-1:0]   LAST_PTR   = PTR_WIDTH'(DEPTH - 32'd1);
    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

    logic [WIDTH-1:0]       mem_r [DEPTH];
    logic [PTR_WIDTH-1:0]   rd_ptr_r;
    logic [PTR_WIDTH-1:0]   wr_ptr_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic                   push_en_s;
    logic                   pop_en_s;

    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_WIDTH'(1'b1);
    endfunction

    assign empty     = (count_r == '0);
    assign full      = (count_r == FULL_COUNT);
    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];
    assign push_en_s = push && !full;
    assign pop_en_s  = pop && !empty;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset flushes the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_en_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_r <= count_r + COUNT_WIDTH'(1'b1);
                2'b01:   count_r <= count_r - COUNT_WIDTH'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/elastic_alu_output_stage_fork.sv
// Eager fork: offers the head token to every enabled output, remembers which
// outputs already took it, and retires the token once all are finished.
module elastic_alu_output_stage_fork #(
    parameter int NUM_OUTPUTS = 32'd4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   head_valid,
    input  logic [NUM_OUTPUTS-1:0] output_mask,
    input  logic [NUM_OUTPUTS-1:0] out_stop,
    output logic [NUM_OUTPUTS-1:0] out_valid,
    output logic                   retire
);
    logic [NUM_OUTPUTS-1:0] done_r;
    logic [NUM_OUTPUTS-1:0] handshake_s;
    logic [NUM_OUTPUTS-1:0] finished_s;

    // Per-output valid/finished decode; a zero mask makes every output finished.
    always_comb begin
        out_valid   = {NUM_OUTPUTS{head_valid}} & output_mask & ~done_r;
        handshake_s = out_valid & ~out_stop;
        finished_s  = done_r | ~output_mask | handshake_s;
        retire      = head_valid && (&finished_s);
    end

    // Done bits: collect handshakes until retirement, then clear for the next token.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r <= '0;
        end else if (retire) begin
            done_r <= '0;
        end else if (head_valid) begin
            done_r <= done_r | handshake_s;
        end else begin
            done_r <= done_r;
        end
    end

endmodule

// File: rtl/elastic_alu_output_stage.sv
// Output half of an elastic CGRA PE: combinational ALU, FIFO elastic buffer
// and eager fork to neighbour PEs, with context-switch pulses per stage.
module elastic_alu_output_stage
    import elastic_alu_output_stage_pkg::*;
#(
    parameter int DATA_WIDTH           = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH        = DEFAULT_ADDRESS_WIDTH,
    parameter int OPERATION_BIT_LENGTH = 32'd4,
    parameter int NUM_OUTPUTS          = 32'd4,
    parameter int BUFFER_DEPTH         = 32'd2
) (
    input logic                        clk,
    input logic                        reset_n,
    elastic_alu_output_stage_if.master bus
);
    localparam int SHIFT_WIDTH = (DATA_WIDTH > 32'd1) ? $clog2(DATA_WIDTH) : 32'd1;

    logic [31:0]              op_code_s;
    logic [DATA_WIDTH-1:0]    result_s;
    logic [DATA_WIDTH-1:0]    head_s;
    logic [ADDRESS_WIDTH-1:0] address_s;
    logic                     is_store_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic                     consume_s;
    logic                     push_s;
    logic                     retire_s;

    assign op_code_s = 32'(bus.op);
    assign address_s = ADDRESS_WIDTH'(bus.in_data_1);

    // ALU datapath under the current context opcode; unknown opcodes pass in1.
    always_comb begin
        result_s   = bus.in_data_1;
        is_store_s = 1'b0;
        case (op_code_s)
            OP_NOP:   result_s = bus.in_data_1;
            OP_ADD:   result_s = bus.in_data_1 + bus.in_data_2;
            OP_SUB:   result_s = bus.in_data_1 - bus.in_data_2;
            OP_MUL:   result_s = bus.in_data_1 * bus.in_data_2;
            OP_AND:   result_s = bus.in_data_1 & bus.in_data_2;
            OP_OR:    result_s = bus.in_data_1 | bus.in_data_2;
            OP_XOR:   result_s = bus.in_data_1 ^ bus.in_data_2;
            OP_SHL:   result_s = bus.in_data_1 << bus.in_data_2[SHIFT_WIDTH-1:0];
            OP_SHR:   result_s = bus.in_data_1 >> bus.in_data_2[SHIFT_WIDTH-1:0];
            OP_CONST: result_s = bus.const_data;
            OP_LOAD:  result_s = bus.memory_read_data;
            OP_STORE: is_store_s = 1'b1;
            default:  result_s = bus.in_data_1;
        endcase
    end

    // Input handshake and memory side. A STORE never needs buffer space, and
    // nothing is consumed (so no write strobe) while reset is held.
    always_comb begin
        bus.in_stop              = is_store_s ? 1'b0 : fifo_full_s;
        consume_s                = bus.in_valid && !bus.in_stop && !reset_n;
        push_s                   = consume_s && !is_store_s;
        bus.memory_write         = consume_s && is_store_s;
        bus.switch_context_alu   = consume_s;
        bus.switch_context_fork  = retire_s;
        bus.memory_read_address  = address_s;
        bus.memory_write_address = address_s;
        bus.memory_write_data    = bus.in_data_2;
    end

    assign bus.out_data = {NUM_OUTPUTS{head_s}};

    elastic_alu_output_stage_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset_n),
        .push      (push_s),
        .push_data (result_s),
        .pop       (retire_s),
        .head_data (head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (bus.buffer_count)
    );

    elastic_alu_output_stage_fork #(
        .NUM_OUTPUTS (NUM_OUTPUTS)
    ) u_fork (
        .clk         (clk),
        .rst         (reset_n),
        .head_valid  (!fifo_empty_s),
        .output_mask (bus.output_mask),
        .out_stop    (bus.out_stop),
        .out_valid   (bus.out_valid),
        .retire      (retire_s)
    );

endmodule

// File: tb/tb_elastic_alu_output_stage.sv
// Directed self-checking bench for elastic_alu_output_stage.
module tb_elastic_alu_output_stage;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    elastic_alu_output_stage_if #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .OPERATION_BIT_LENGTH(4),
        .NUM_OUTPUTS(4), .BUFFER_DEPTH(2)
    ) bus ();

    elastic_alu_output_stage #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .OPERATION_BIT_LENGTH(4),
        .NUM_OUTPUTS(4), .BUFFER_DEPTH(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Back-to-back opcode table with hand-computed results.
    logic [3:0]  b2b_op  [11] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd15, 4'd1, 4'd2};
    logic [31:0] b2b_a   [11] = '{32'h0001_0003, 32'h0000_F0F0, 32'h0000_F0F0, 32'hFFFF_0000,
                                  32'h0000_0001, 32'h8000_0000, 32'h0000_0777, 32'h0000_1234,
                                  32'h0000_ABCD, 32'hFFFF_FFFF, 32'h0000_0010};
    logic [31:0] b2b_b   [11] = '{32'h0001_0005, 32'h0000_FF00, 32'h0000_0F00, 32'h0F0F_0F0F,
                                  32'h0000_0024, 32'h0000_0003, 32'h0000_0001, 32'h0000_9999,
                                  32'h0000_5555, 32'h0000_0002, 32'h0000_0003};
    logic [31:0] b2b_exp [11] = '{32'h0008_000F, 32'h0000_F000, 32'h0000_FFF0, 32'hF0F0_0F0F,
                                  32'h0000_0010, 32'h1000_0000, 32'hCAFE_BABE, 32'h0000_1234,
                                  32'h0000_ABCD, 32'h0000_0001, 32'h0000_000D};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_token(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op        = op;
        bus.in_data_1 = a;
        bus.in_data_2 = b;
        bus.in_valid  = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        bus.in_valid = 1'b0; bus.op = 4'd0; bus.in_data_1 = 32'd0; bus.in_data_2 = 32'd0;
        bus.const_data = 32'hCAFE_BABE; bus.output_mask = 4'b0000; bus.out_stop = 4'b0000;
        bus.memory_read_data = 32'd0;
        tick(); tick();
        mid();
        total++; if (bus.buffer_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.buffer_count); end
        total++; if (bus.out_valid !== 4'b0000) begin bad++; $display("FAIL reset_out_valid got=%b want=0000", bus.out_valid); end
        total++; if (bus.in_stop !== 1'b0) begin bad++; $display("FAIL reset_in_stop got=%b want=0", bus.in_stop); end
        total++; if ({bus.memory_write, bus.switch_context_alu, bus.switch_context_fork} !== 3'b000) begin
            bad++; $display("FAIL reset_pulses got=%b want=000", {bus.memory_write, bus.switch_context_alu, bus.switch_context_fork}); end
        tick();
        reset_n = 1'b0;
        tick();
    endtask

    task automatic test_add();
        bus.output_mask = 4'b0011; bus.out_stop = 4'b0000;
        drive_token(4'd1, 32'd3, 32'd5);
        mid();
        total++; if (bus.switch_context_alu !== 1'b1) begin bad++; $display("FAIL add_alu_pulse got=%b want=1", bus.switch_context_alu); end
        total++; if (bus.out_valid !== 4'b0000) begin bad++; $display("FAIL add_latency got=%b want=0000", bus.out_valid); end
        tick();
        bus.in_valid = 1'b0;
        mid();
        total++; if (bus.out_valid !== 4'b0011) begin bad++; $display("FAIL add_out_valid got=%b want=0011", bus.out_valid); end
        total++; if (bus.out_data[0] !== 32'd8 || bus.out_data[1] !== 32'd8) begin
            bad++; $display("FAIL add_out_data got=%h/%h want=8", bus.out_data[0], bus.out_data[1]); end
        total++; if (bus.switch_context_fork !== 1'b1) begin bad++; $display("FAIL add_fork_pulse got=%b want=1", bus.switch_context_fork); end
        total++; if (bus.switch_context_alu !== 1'b0) begin bad++; $display("FAIL add_alu_idle got=%b want=0", bus.switch_context_alu); end
        tick();
        mid();
        total++; if (bus.buffer_count !== 2'd0) begin bad++; $display("FAIL add_count_after got=%0d want=0", bus.buffer_count); end
        total++; if (bus.out_valid !== 4'b0000 || bus.switch_context_fork !== 1'b0) begin
            bad++; $display("FAIL add_idle_after got=%b/%b want=0000/0", bus.out_valid, bus.switch_context_fork); end
        tick();
    endtask

    task automatic test_partial_stop();
        int fork_pulses;
        logic [3:0] exp_valid [5] = '{4'b0011, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
        fork_pulses = 0;
        bus.output_mask = 4'b0011;
        drive_token(4'd1, 32'd10, 32'd20);
        tick();
        bus.in_valid = 1'b0;
        bus.out_stop = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) bus.out_stop = 4'b0000;
            mid();
            if (bus.switch_context_fork === 1'b1) fork_pulses++;
            total++; if (bus.out_valid !== exp_valid[c]) begin
                bad++; $display("FAIL partial_out_valid cycle=%0d got=%b want=%b", c, bus.out_valid, exp_valid[c]); end
            if (c == 3) begin
                total++; if (bus.out_data[1] !== 32'd30) begin bad++; $display("FAIL partial_out_data got=%h want=1e", bus.out_data[1]); end
                total++; if (bus.switch_context_fork !== 1'b1) begin bad++; $display("FAIL partial_retire got=%b want=1", bus.switch_context_fork); end
            end
            tick();
        end
        total++; if (fork_pulses != 1) begin bad++; $display("FAIL partial_fork_count got=%0d want=1", fork_pulses); end
    endtask

    task automatic test_backpressure();
        bus.output_mask = 4'b1111; bus.out_stop = 4'b1111;
        drive_token(4'd1, 32'd1, 32'd0);
        mid();
        total++; if (bus.in_stop !== 1'b0 || bus.switch_context_alu !== 1'b1) begin
            bad++; $display("FAIL bp_tok1 got stop=%b alu=%b want 0/1", bus.in_stop, bus.switch_context_alu); end
        tick();
        drive_token(4'd1, 32'd2, 32'd0);
        tick();
        drive_token(4'd1, 32'd3, 32'd0);
        mid();
        total++; if (bus.buffer_count !== 2'd2) begin bad++; $display("FAIL bp_count_full got=%0d want=2", bus.buffer_count); end
        total++; if (bus.in_stop !== 1'b1 || bus.switch_context_alu !== 1'b0) begin
            bad++; $display("FAIL bp_held got stop=%b alu=%b want 1/0", bus.in_stop, bus.switch_context_alu); end
        tick();
        drive_token(4'd11, 32'h20, 32'h77);
        mid();
        total++; if (bus.in_stop !== 1'b0 || bus.memory_write !== 1'b1) begin
            bad++; $display("FAIL bp_store_full got stop=%b wr=%b want 0/1", bus.in_stop, bus.memory_write); end
        tick();
        drive_token(4'd1, 32'd3, 32'd0);
        bus.out_stop = 4'b0000;
        mid();
        total++; if (bus.buffer_count !== 2'd2 || bus.in_stop !== 1'b1 || bus.switch_context_alu !== 1'b0) begin
            bad++; $display("FAIL bp_release got cnt=%0d stop=%b alu=%b want 2/1/0", bus.buffer_count, bus.in_stop, bus.switch_context_alu); end
        total++; if (bus.out_data[0] !== 32'd1 || bus.switch_context_fork !== 1'b1) begin
            bad++; $display("FAIL bp_head1 got %h/%b want 1/1", bus.out_data[0], bus.switch_context_fork); end
        tick();
        mid();
        total++; if (bus.switch_context_alu !== 1'b1 || bus.out_data[0] !== 32'd2) begin
            bad++; $display("FAIL bp_push_pop got alu=%b head=%h want 1/2", bus.switch_context_alu, bus.out_data[0]); end
        tick();
        bus.in_valid = 1'b0;
        mid();
        total++; if (bus.buffer_count !== 2'd1 || bus.out_data[0] !== 32'd3) begin
            bad++; $display("FAIL bp_tok3 got cnt=%0d head=%h want 1/3", bus.buffer_count, bus.out_data[0]); end
        tick();
        mid();
        total++; if (bus.buffer_count !== 2'd0) begin bad++; $display("FAIL bp_drained got=%0d want=0", bus.buffer_count); end
        tick();
    endtask

    task automatic test_store_load();
        bus.output_mask = 4'b0001; bus.out_stop = 4'b0000;
        drive_token(4'd11, 32'h10, 32'h55);
        mid();
        total++; if (bus.memory_write !== 1'b1 || bus.memory_write_address !== 32'h10 || bus.memory_write_data !== 32'h55) begin
            bad++; $display("FAIL store_write got wr=%b addr=%h data=%h want 1/10/55", bus.memory_write, bus.memory_write_address, bus.memory_write_data); end
        total++; if (bus.switch_context_alu !== 1'b1 || bus.in_stop !== 1'b0) begin
            bad++; $display("FAIL store_consume got alu=%b stop=%b want 1/0", bus.switch_context_alu, bus.in_stop); end
        tick();
        drive_token(4'd10, 32'h10, 32'h0);
        bus.memory_read_data = 32'h55;
        mid();
        total++; if (bus.memory_write !== 1'b0 || bus.memory_read_address !== 32'h10) begin
            bad++; $display("FAIL load_addr got wr=%b raddr=%h want 0/10", bus.memory_write, bus.memory_read_address); end
        total++; if (bus.out_valid !== 4'b0000 || bus.buffer_count !== 2'd0) begin
            bad++; $display("FAIL store_no_token got valid=%b cnt=%0d want 0000/0", bus.out_valid, bus.buffer_count); end
        tick();
        bus.in_valid = 1'b0;
        bus.memory_read_data = 32'h0;
        mid();
        total++; if (bus.out_valid !== 4'b0001 || bus.out_data[0] !== 32'h55) begin
            bad++; $display("FAIL load_result got valid=%b data=%h want 0001/55", bus.out_valid, bus.out_data[0]); end
        tick();
    endtask

    task automatic test_sink_and_wrap();
        bus.output_mask = 4'b0000;
        drive_token(4'd2, 32'd2, 32'd5);
        tick();
        bus.in_valid = 1'b0;
        mid();
        total++; if (bus.buffer_count !== 2'd1 || bus.switch_context_fork !== 1'b1 || bus.out_valid !== 4'b0000) begin
            bad++; $display("FAIL sink got cnt=%0d fork=%b valid=%b want 1/1/0000", bus.buffer_count, bus.switch_context_fork, bus.out_valid); end
        tick();
        mid();
        total++; if (bus.buffer_count !== 2'd0 || bus.switch_context_fork !== 1'b0) begin
            bad++; $display("FAIL sink_after got cnt=%0d fork=%b want 0/0", bus.buffer_count, bus.switch_context_fork); end
        tick();
        bus.output_mask = 4'b0100;
        drive_token(4'd2, 32'd2, 32'd5);
        tick();
        bus.in_valid = 1'b0;
        mid();
        total++; if (bus.out_valid !== 4'b0100 || bus.out_data[2] !== 32'hFFFF_FFFD) begin
            bad++; $display("FAIL sub_wrap got valid=%b data=%h want 0100/fffffffd", bus.out_valid, bus.out_data[2]); end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.output_mask = 4'b0001; bus.out_stop = 4'b0000; bus.const_data = 32'hCAFE_BABE;
        for (int k = 0; k <= 11; k++) begin
            if (k < 11) drive_token(b2b_op[k], b2b_a[k], b2b_b[k]);
            else bus.in_valid = 1'b0;
            mid();
            if (k < 11) begin
                total++; if (bus.switch_context_alu !== 1'b1) begin
                    bad++; $display("FAIL b2b_accept idx=%0d got=%b want=1", k, bus.switch_context_alu); end
            end
            if (k > 0) begin
                total++; if (bus.out_valid[0] !== 1'b1 || bus.out_data[0] !== b2b_exp[k-1]) begin
                    bad++; $display("FAIL b2b_result idx=%0d got=%h want=%h", k - 1, bus.out_data[0], b2b_exp[k-1]); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        bus.output_mask = 4'b1111; bus.out_stop = 4'b1111;
        drive_token(4'd1, 32'd4, 32'd4);
        tick();
        drive_token(4'd1, 32'd5, 32'd5);
        tick();
        bus.in_valid = 1'b0;
        mid();
        total++; if (bus.buffer_count !== 2'd2) begin bad++; $display("FAIL rst_mid_fill got=%0d want=2", bus.buffer_count); end
        tick();
        drive_token(4'd11, 32'h30, 32'h99);
        reset_n = 1'b1;
        #1;
        total++; if (bus.buffer_count !== 2'd0 || bus.out_valid !== 4'b0000) begin
            bad++; $display("FAIL rst_mid_flush got cnt=%0d valid=%b want 0/0000", bus.buffer_count, bus.out_valid); end
        total++; if (bus.memory_write !== 1'b0 || bus.switch_context_alu !== 1'b0) begin
            bad++; $display("FAIL rst_mid_no_write got wr=%b alu=%b want 0/0", bus.memory_write, bus.switch_context_alu); end
        tick();
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        bus.out_stop = 4'b0000; bus.output_mask = 4'b0001;
        tick();
        drive_token(4'd1, 32'd7, 32'd1);
        mid();
        total++; if (bus.switch_context_alu !== 1'b1) begin bad++; $display("FAIL rst_mid_new_accept got=%b want=1", bus.switch_context_alu); end
        tick();
        bus.in_valid = 1'b0;
        mid();
        total++; if (bus.out_valid !== 4'b0001 || bus.out_data[0] !== 32'd8 || bus.switch_context_fork !== 1'b1) begin
            bad++; $display("FAIL rst_mid_new_token got valid=%b data=%h fork=%b want 0001/8/1", bus.out_valid, bus.out_data[0], bus.switch_context_fork); end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add();
        test_partial_stop();
        test_backpressure();
        test_store_load();
        test_sink_and_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
